// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the sequential ALU.
package alu_pkg;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_MAX  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_SHL  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: loads on start, then one multiplier bit per step.
module alu_mul_iter #(
  parameter int A_W = 4,
  parameter int B_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               step,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic               done,
  output logic [A_W+B_W-1:0] product
);

  localparam int RES_W = A_W + B_W;
  localparam int CNT_W = $clog2(A_W + 1);

  logic [A_W-1:0]   mplier_reg;
  logic [RES_W-1:0] mcand_reg;
  logic [RES_W-1:0] acc_reg;
  logic [RES_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt_reg;

  always_comb begin
    acc_next = acc_reg;
    if (mplier_reg[0]) begin
      acc_next = acc_reg + mcand_reg;
    end
  end

  // done flags the final step so the caller can latch acc_next on that same edge
  assign done    = step && (cnt_reg == CNT_W'(A_W - 1));
  assign product = acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mplier_reg <= '0;
      mcand_reg  <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
    end else if (start) begin
      mplier_reg <= a;
      mcand_reg  <= RES_W'(b);
      acc_reg    <= '0;
      cnt_reg    <= '0;
    end else if (step && (cnt_reg != CNT_W'(A_W))) begin
      acc_reg    <= acc_next;
      mplier_reg <= mplier_reg >> 1;
      mcand_reg  <= mcand_reg << 1;
      cnt_reg    <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle ops registered on accept, multiply via alu_mul_iter.
module seq_alu
  import alu_pkg::*;
#(
  parameter int A_W = 4,
  parameter int B_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_W-1:0]       a,
  input  logic [B_W-1:0]       b,
  input  logic [2:0]           command,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [A_W+B_W-1:0]   result,
  output logic                 flag_z,
  output logic                 flag_b
);

  localparam int RES_W = A_W + B_W;

  state_t           state_reg;
  logic [RES_W-1:0] a_ext;
  logic [RES_W-1:0] b_ext;
  logic [RES_W-1:0] alu_res;
  logic             alu_borrow;
  logic             accept;
  logic             mul_start;
  logic             mul_step;
  logic             mul_done;
  logic [RES_W-1:0] mul_prod;

  assign accept    = (state_reg == ST_IDLE) && in_ready && in_valid;
  assign mul_start = accept && (command == OP_MUL);
  assign mul_step  = (state_reg == ST_BUSY);

  always_comb begin
    a_ext      = RES_W'(a);
    b_ext      = RES_W'(b);
    alu_res    = '0;
    alu_borrow = 1'b0;
    case (command)
      OP_PASS: alu_res = a_ext;
      OP_ADD:  alu_res = a_ext + b_ext;
      OP_SUB: begin
        alu_res    = a_ext - b_ext;
        alu_borrow = (a_ext < b_ext);
      end
      OP_AND:  alu_res = a_ext & b_ext;
      OP_OR:   alu_res = a_ext | b_ext;
      OP_MAX:  alu_res = (a_ext > b_ext) ? a_ext : b_ext;
      OP_SHL:  alu_res = (b_ext >= RES_W'(RES_W)) ? '0 : (a_ext << b);
      default: alu_res = '0;
    endcase
  end

  alu_mul_iter #(
    .A_W(A_W),
    .B_W(B_W)
  ) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (mul_start),
    .step   (mul_step),
    .a      (a),
    .b      (b),
    .done   (mul_done),
    .product(mul_prod)
  );

  // in_ready comes up one clock after reset release, then tracks IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      flag_z    <= 1'b0;
      flag_b    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (command == OP_MUL) begin
              state_reg <= ST_BUSY;
            end else begin
              state_reg <= ST_DONE;
              out_valid <= 1'b1;
              result    <= alu_res;
              flag_z    <= (alu_res == '0);
              flag_b    <= alu_borrow;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (mul_done) begin
            state_reg <= ST_DONE;
            out_valid <= 1'b1;
            result    <= mul_prod;
            flag_z    <= (mul_prod == '0);
            flag_b    <= 1'b0;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_reg <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Randomised and directed checks of seq_alu against an arithmetic reference model.
module tb_seq_alu;

  localparam int A_W   = 4;
  localparam int B_W   = 5;
  localparam int RES_W = A_W + B_W;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [A_W-1:0]   a;
  logic [B_W-1:0]   b;
  logic [2:0]       command;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] result;
  logic             flag_z;
  logic             flag_b;

  int checks_cnt;
  int errors_cnt;

  seq_alu #(.A_W(A_W), .B_W(B_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .command  (command),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .flag_z   (flag_z),
    .flag_b   (flag_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain unsigned arithmetic, wrapped to RES_W bits.
  function automatic void model(input int av, input int bv, input int cmd,
                                output int res, output int bor, output int lat);
    int m;
    m   = 1 << RES_W;
    bor = 0;
    lat = 1;
    case (cmd)
      0: res = av;
      1: res = av + bv;
      2: begin res = (av - bv + m) % m; bor = (av < bv) ? 1 : 0; end
      3: res = av & bv;
      4: res = av | bv;
      5: res = (av > bv) ? av : bv;
      6: begin res = av * bv; lat = A_W + 1; end
      default: res = (bv >= RES_W) ? 0 : ((av << bv) % m);
    endcase
  endfunction

  task automatic run_op(input int av, input int bv, input int cmd, input int hold);
    int exp_res, exp_bor, exp_lat, lat, n;
    string t;
    model(av, bv, cmd, exp_res, exp_bor, exp_lat);
    n = 0;
    while (!in_ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_idle", int'(in_ready), 1);
    a        = A_W'(av);
    b        = B_W'(bv);
    command  = 3'(cmd);
    in_valid = 1'b1;
    @(posedge clk); #1;
    // scramble inputs after accept; random in_valid must be ignored while busy
    a        = A_W'($urandom);
    b        = B_W'($urandom);
    command  = 3'($urandom);
    in_valid = 1'($urandom_range(0, 1));
    lat = 1;
    while (!out_valid && lat < 20) begin
      check("in_ready_busy", int'(in_ready), 0);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    t = $sformatf("op%0d a=%0d b=%0d", cmd, av, bv);
    check({t, " latency"}, lat, exp_lat);
    check({t, " result"}, int'(result), exp_res);
    check({t, " flag_z"}, int'(flag_z), (exp_res == 0) ? 1 : 0);
    check({t, " flag_b"}, int'(flag_b), exp_bor);
    check({t, " in_ready_done"}, int'(in_ready), 0);
    repeat (hold) begin
      in_valid = 1'($urandom_range(0, 1));
      command  = 3'($urandom);
      @(posedge clk); #1;
      check("hold out_valid", int'(out_valid), 1);
      check("hold result", int'(result), exp_res);
      check("hold flags", int'({flag_z, flag_b}), ((exp_res == 0) ? 2 : 0) + exp_bor);
    end
    // consume with a simultaneous in_valid that must be dropped
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("consume out_valid", int'(out_valid), 0);
    check("consume in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    check("dropped in_valid", int'(out_valid), 0);
    $display("op cmd=%0d a=%0d b=%0d result=%0d z=%0d b=%0d lat=%0d hold=%0d",
             cmd, av, bv, exp_res, (exp_res == 0) ? 1 : 0, exp_bor, lat, hold);
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    a          = '0;
    b          = '0;
    command    = '0;
    #12;
    check("reset in_ready", int'(in_ready), 0);
    check("reset out_valid", int'(out_valid), 0);
    check("reset result", int'(result), 0);
    check("reset flags", int'({flag_z, flag_b}), 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-reset in_ready", int'(in_ready), 1);

    // abort a multiply two cycles into BUSY
    a = 4'd15; b = 5'd12; command = 3'b110; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    check("abort out_valid", int'(out_valid), 0);
    check("abort result", int'(result), 0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort in_ready", int'(in_ready), 1);
    repeat (6) begin
      @(posedge clk); #1;
      check("abort no result", int'(out_valid), 0);
    end
    run_op(1, 1, 1, 0);

    run_op(10, 1, 1, 0);
    run_op(10, 1, 2, 0);
    run_op(12, 15, 2, 0);
    run_op(11, 21, 3, 0);
    run_op(11, 21, 4, 0);
    run_op(15, 12, 5, 0);
    run_op(12, 15, 5, 0);
    run_op(15, 12, 6, 0);
    run_op(15, 31, 6, 6);
    run_op(0, 31, 6, 0);
    run_op(12, 0, 6, 0);
    run_op(12, 21, 7, 0);
    run_op(3, 4, 7, 0);
    run_op(1, 8, 7, 1);
    run_op(0, 0, 0, 6);

    for (int i = 0; i < 40; i++) begin
      run_op($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 7),
             $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, handshaked successor to the team's combinational 3-bit-command ALU. Operands A (A_W bits) and B (B_W bits) and a command are accepted on a valid/ready input handshake. Single-cycle operations are registered. Multiply runs as an iterative shift-add over A_W cycles. The result is held on a valid/ready output handshake until consumed, with zero and borrow flags, so the block can sit between pipelined producers and consumers.

Parameters:
A_W, 4, width of operand A (≥2)
B_W, 5, width of operand B (≥2)
RES_W, A_W+B_W, result width; localparam, not overridable
CNT_W, $clog2(A_W+1), multiply step counter width; localparam

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand/command valid
in_ready  out  1  block can accept a command
a  in  A_W  operand A, unsigned
b  in  B_W  operand B, unsigned
command  in  3  operation select
out_valid  out  1  result valid
out_ready  in  1  consumer takes result
result  out  RES_W  operation result
flag_z  out  1  result == 0
flag_b  out  1  borrow from SUB, 0 for all other commands

Behaviour:
- Reset is asynchronous and active-low; one clock domain. While rst_n=0: state=IDLE, in_ready=0 and then 1 from the first clock after release, out_valid=0, result=0, flags=0, counter=0.
- Reset mid-multiply or with a result pending aborts the operation; the result is lost.
- FSM states:
  - IDLE: in_ready=1.
  - BUSY: multiply running; in_ready=0.
  - DONE: out_valid=1; in_ready=0.
- Transitions:
  - IDLE→DONE on in_valid for any command other than 110.
  - IDLE→BUSY on in_valid with command 110.
  - BUSY→DONE when counter reaches A_W.
  - DONE→IDLE on out_ready.
  - A new command cannot be accepted in DONE, even when out_ready=1. Maximum throughput is one op per 2 cycles.
- Accept edge: a, b and command are captured. Input changes after this edge do not affect the operation.
- Commands (operands zero-extended to RES_W; result truncated to RES_W):
  - 000: pass A.
  - 001: A+B (never overflows RES_W).
  - 010: A−B, two's complement modulo 2^RES_W; flag_b=1 iff A<B.
  - 011: A&B.
  - 100: A|B.
  - 101: unsigned max(A,B).
  - 110: A*B, iterative. Each BUSY cycle examines one bit of A (LSB first) and adds B shifted left by the step index into the accumulator.
  - 111: A<<B. If B ≥ RES_W, result=0.
- Latency from accept edge to out_valid: 1 cycle for single-cycle ops; A_W+1 cycles for multiply (1 load + A_W steps, DONE reached on the A_W-th step edge).
- result, flag_z and flag_b are registered and stable throughout DONE. They hold their last value in IDLE and BUSY.
- flag_z is computed on the final result for every command.
- out_valid rises only in DONE and falls on the edge where out_ready=1 was sampled.
- Simultaneous in_valid and out_ready in DONE: out_ready is honoured and in_valid is ignored; the producer retries in IDLE.
- in_valid in BUSY or DONE is ignored; no queueing.
- Boundaries:
  - A=0 or B=0 multiply still takes the full A_W steps.
  - Max operands, multiply: (2^A_W−1)(2^B_W−1) fits RES_W.

Decomposition:
- Package alu_pkg holds:
  - the 3-bit opcode constants: OP_PASS, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MAX, OP_MUL, OP_SHL
  - the state encoding: ST_IDLE, ST_BUSY, ST_DONE
- One sub-module, alu_mul_iter (start/step/done, shift-add datapath with counter), instantiated once. All other ops stay inline in a combinational case feeding the result register.

Test Plan:
- Reset with rst_n=0 mid-multiply (a=15, b=12, two cycles into BUSY) -> out_valid=0, result=0, in_ready=1 after release; next ADD a=1, b=1 gives 2.
- a=10, b=1: cmd 001 -> result=11, out_valid one cycle after accept; cmd 010 -> 9, flag_b=0; a=12, b=15, cmd 010 -> 509, flag_b=1.
- a=11, b=21: cmd 011 -> 1; cmd 100 -> 31; cmd 101 with a=15, b=12 -> 15; with a=12, b=15 -> 15.
- a=15, b=12, cmd 110 -> in_ready=0 for the whole of BUSY, out_valid exactly 5 cycles after accept, result=180; a=15, b=31 -> 465; a=0, b=31 -> 0 with flag_z=1, same latency.
- a=12, b=21, cmd 111 -> result=0, flag_z=1; a=3, b=4 -> 48.
- Backpressure: out_ready=0 for 6 cycles -> result and flags stable and out_valid held; in_valid pulses meanwhile are ignored; out_ready=1 -> IDLE next cycle; a simultaneous in_valid is dropped.
